// File: rtl/lap_stopwatch_pkg.sv
// rtl/lap_stopwatch_pkg.sv - shared constants and FSM encoding for the lap stopwatch
// Contents:
//   DIGIT_W : bits per BCD digit
//   state_e : stopwatch control states
package lap_stopwatch_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

endpackage

// File: rtl/bcd_updown_counter.sv
// rtl/bcd_updown_counter.sv - NDIG-digit BCD up/down counter with load and zero flags
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   load_i        : load load_val_i (digits above 9 clamp to 9)
//   load_val_i    : BCD load value
//   step_i        : advance one count in the direction given by down_i
//   down_i        : 0 = increment, 1 = decrement
//   count_o       : registered BCD count
//   zero_o        : count_o is zero
//   step_zero_o   : the value a step would produce this cycle is zero
module bcd_updown_counter
  import lap_stopwatch_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_i,
  input  logic [DIGIT_W*NDIG-1:0] load_val_i,
  input  logic                    step_i,
  input  logic                    down_i,
  output logic [DIGIT_W*NDIG-1:0] count_o,
  output logic                    zero_o,
  output logic                    step_zero_o
);

  localparam int TW = DIGIT_W * NDIG;

  logic [TW-1:0] count_q, count_d;
  logic [TW-1:0] stepped;
  logic [TW-1:0] load_clean;

  // Ripple carry/borrow through the digits; only digits reached by the
  // carry chain change, so 9->0 (up) and 0->9 (down) propagate naturally.
  always_comb begin : step_calc
    logic                carry;
    logic [DIGIT_W-1:0]  digit;
    stepped = count_q;
    carry   = 1'b1;
    digit   = '0;
    for (int i = 0; i < NDIG; i++) begin
      digit = count_q[i*DIGIT_W +: DIGIT_W];
      if (carry) begin
        if (down_i) begin
          if (digit == '0) begin
            digit = DIGIT_W'(9);
          end else begin
            digit = digit - DIGIT_W'(1);
            carry = 1'b0;
          end
        end else begin
          if (digit >= DIGIT_W'(9)) begin
            digit = '0;
          end else begin
            digit = digit + DIGIT_W'(1);
            carry = 1'b0;
          end
        end
      end
      stepped[i*DIGIT_W +: DIGIT_W] = digit;
    end
  end

  // Non-BCD preset digits are clamped so the count never holds 10..15.
  always_comb begin
    load_clean = load_val_i;
    for (int i = 0; i < NDIG; i++) begin
      if (load_val_i[i*DIGIT_W +: DIGIT_W] > DIGIT_W'(9)) begin
        load_clean[i*DIGIT_W +: DIGIT_W] = DIGIT_W'(9);
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_clean;
    end else if (step_i) begin
      count_d = stepped;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o     = count_q;
  assign zero_o      = (count_q == '0);
  assign step_zero_o = (stepped == '0);

endmodule

// File: rtl/lap_stopwatch.sv
// rtl/lap_stopwatch.sv - BCD stopwatch with up/down count, split display and lap buffer
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   start_stop, split, lap,
//   lap_next, load             : one-cycle control pulses
//   dir, preset                : count direction and BCD preset, taken on load
//   time_bcd, disp_bcd         : live time and (possibly frozen) display time
//   lap_bcd, lap_cnt, lap_full : lap entry at read index, valid entries, full flag
//   running, split_active,
//   expired                    : status
module lap_stopwatch
  import lap_stopwatch_pkg::*;
#(
  parameter int CLK_FREQ  = 100000000,
  parameter int NDIG      = 4,
  parameter int LAP_DEPTH = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start_stop,
  input  logic                             split,
  input  logic                             lap,
  input  logic                             lap_next,
  input  logic                             dir,
  input  logic [DIGIT_W*NDIG-1:0]          preset,
  input  logic                             load,
  output logic [DIGIT_W*NDIG-1:0]          time_bcd,
  output logic [DIGIT_W*NDIG-1:0]          disp_bcd,
  output logic [DIGIT_W*NDIG-1:0]          lap_bcd,
  output logic [$clog2(LAP_DEPTH+1)-1:0]   lap_cnt,
  output logic                             lap_full,
  output logic                             running,
  output logic                             split_active,
  output logic                             expired
);

  localparam int TW = DIGIT_W * NDIG;
  localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam int IW = $clog2(LAP_DEPTH);
  localparam int CW = $clog2(LAP_DEPTH + 1);

  state_e        state_q, state_d;
  logic          dir_q;
  logic [TW-1:0] preset_q;
  logic [PW-1:0] presc_q;
  logic [TW-1:0] snap_q;
  logic          split_q;
  logic [TW-1:0] lap_mem_q [LAP_DEPTH];
  logic [IW-1:0] wr_ptr_q, rd_idx_q;
  logic [CW-1:0] lap_cnt_q;

  logic          load_ok, ss_ok, step_en, expire, cnt_ld;
  logic          cnt_zero, cnt_step_zero, full;
  logic [TW-1:0] cnt_ld_val;
  logic [IW-1:0] oldest_idx;

  assign load_ok = load && (state_q != ST_RUN);
  assign step_en = (state_q == ST_RUN) && (presc_q == PW'(CLK_FREQ - 1));
  assign expire  = step_en && dir_q && cnt_step_zero;
  assign full    = (lap_cnt_q == CW'(LAP_DEPTH));

  // Restart from EXPIRED reloads the preset latched at the last load.
  assign cnt_ld     = load_ok || ((state_q == ST_EXPIRED) && start_stop);
  assign cnt_ld_val = load_ok ? preset : preset_q;

  bcd_updown_counter #(.NDIG(NDIG)) u_counter (
    .clk         (clk),
    .reset       (reset),
    .load_i      (cnt_ld),
    .load_val_i  (cnt_ld_val),
    .step_i      (step_en),
    .down_i      (dir_q),
    .count_o     (time_bcd),
    .zero_o      (cnt_zero),
    .step_zero_o (cnt_step_zero)
  );

  // Expiry beats a same-cycle start_stop so the count never pauses at zero.
  always_comb begin
    state_d = state_q;
    ss_ok   = 1'b0;
    if (load_ok) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_stop && !(dir_q && cnt_zero)) begin
            state_d = ST_RUN;
            ss_ok   = 1'b1;
          end
        end
        ST_RUN: begin
          if (expire) begin
            state_d = ST_EXPIRED;
          end else if (start_stop) begin
            state_d = ST_PAUSE;
            ss_ok   = 1'b1;
          end
        end
        ST_PAUSE: begin
          if (start_stop) begin
            state_d = ST_RUN;
            ss_ok   = 1'b1;
          end
        end
        ST_EXPIRED: begin
          if (start_stop) begin
            state_d = ST_IDLE;
            ss_ok   = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Laps fill slots 0.. until full; after that wr_ptr_q holds the oldest.
  assign oldest_idx = full ? wr_ptr_q : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      dir_q     <= 1'b0;
      preset_q  <= '0;
      presc_q   <= '0;
      snap_q    <= '0;
      split_q   <= 1'b0;
      wr_ptr_q  <= '0;
      rd_idx_q  <= '0;
      lap_cnt_q <= '0;
      for (int i = 0; i < LAP_DEPTH; i++) begin
        lap_mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;

      if (load_ok) begin
        dir_q    <= dir;
        preset_q <= preset;
      end

      if (load_ok) begin
        presc_q <= '0;
      end else if (state_q == ST_RUN) begin
        presc_q <= step_en ? '0 : presc_q + PW'(1);
      end

      if (load_ok || ss_ok) begin
        split_q <= 1'b0;
      end else if (split && split_q) begin
        split_q <= 1'b0;
      end else if (split && (state_q == ST_RUN)) begin
        split_q <= 1'b1;
        snap_q  <= time_bcd;
      end

      if (load_ok) begin
        wr_ptr_q  <= '0;
        rd_idx_q  <= '0;
        lap_cnt_q <= '0;
      end else if (lap && ((state_q == ST_RUN) || (state_q == ST_PAUSE))) begin
        lap_mem_q[wr_ptr_q] <= time_bcd;
        rd_idx_q            <= wr_ptr_q;
        wr_ptr_q            <= wr_ptr_q + IW'(1);
        if (!full) begin
          lap_cnt_q <= lap_cnt_q + CW'(1);
        end
      end else if (lap_next && (lap_cnt_q != '0)) begin
        rd_idx_q <= (rd_idx_q == oldest_idx) ? (wr_ptr_q - IW'(1)) : (rd_idx_q - IW'(1));
      end
    end
  end

  assign disp_bcd     = split_q ? snap_q : time_bcd;
  assign lap_bcd      = (lap_cnt_q == '0) ? '0 : lap_mem_q[rd_idx_q];
  assign lap_cnt      = lap_cnt_q;
  assign lap_full     = full;
  assign running      = (state_q == ST_RUN);
  assign expired      = (state_q == ST_EXPIRED);
  assign split_active = split_q;

endmodule

// File: tb/tb_lap_stopwatch.sv
// tb/tb_lap_stopwatch.sv - directed scoreboard bench for lap_stopwatch
module tb_lap_stopwatch;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start_stop = 1'b0;
  logic       split = 1'b0;
  logic       lap = 1'b0;
  logic       lap_next = 1'b0;
  logic       dir = 1'b0;
  logic [7:0] preset = '0;
  logic       load = 1'b0;
  logic [7:0] time_bcd, disp_bcd, lap_bcd;
  logic [2:0] lap_cnt;
  logic       lap_full, running, split_active, expired;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  lap_stopwatch #(.CLK_FREQ(4), .NDIG(2), .LAP_DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_stop   (start_stop),
    .split        (split),
    .lap          (lap),
    .lap_next     (lap_next),
    .dir          (dir),
    .preset       (preset),
    .load         (load),
    .time_bcd     (time_bcd),
    .disp_bcd     (disp_bcd),
    .lap_bcd      (lap_bcd),
    .lap_cnt      (lap_cnt),
    .lap_full     (lap_full),
    .running      (running),
    .split_active (split_active),
    .expired      (expired)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string tag, input logic [31:0] val);
    tag_q.push_back(tag);
    exp_q.push_back(val);
  endtask

  task automatic check(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        fails++;
        $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
      end
    end
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1; tick(1); start_stop = 1'b0;
  endtask

  task automatic pulse_lap();
    lap = 1'b1; tick(1); lap = 1'b0;
  endtask

  task automatic pulse_next();
    lap_next = 1'b1; tick(1); lap_next = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] v, input logic d);
    preset = v; dir = d; load = 1'b1; tick(1); load = 1'b0;
  endtask

  initial begin
    // reset state
    reset = 1'b1; tick(2); reset = 1'b0;
    expect_val("rst_time", 0);    check(time_bcd);
    expect_val("rst_running", 0); check(running);
    expect_val("rst_expired", 0); check(expired);
    expect_val("rst_lap_cnt", 0); check(lap_cnt);
    expect_val("rst_lap_bcd", 0); check(lap_bcd);
    expect_val("rst_split", 0);   check(split_active);

    // 40 run cycles at 4 cycles/step -> 10 steps
    expect_val("run40_time", 8'h10);
    expect_val("run40_running", 1);
    pulse_ss(); tick(40);
    check(time_bcd); check(running);

    // up-count wrap 98 -> 99 -> 00
    pulse_ss();
    expect_val("load98_time", 8'h98);
    do_load(8'h98, 1'b0);
    check(time_bcd);
    expect_val("wrap_99", 8'h99);
    pulse_ss(); tick(4); check(time_bcd);
    expect_val("wrap_00", 8'h00);
    expect_val("wrap_running", 1);
    tick(4); check(time_bcd); check(running);

    // down count to expiry and restart to preset
    pulse_ss();
    do_load(8'h02, 1'b1);
    expect_val("down_01", 8'h01);
    pulse_ss(); tick(4); check(time_bcd);
    expect_val("down_00", 8'h00);
    expect_val("down_expired", 1);
    expect_val("down_not_running", 0);
    tick(4); check(time_bcd); check(expired); check(running);
    expect_val("restart_time", 8'h02);
    expect_val("restart_expired", 0);
    pulse_ss(); check(time_bcd); check(expired);

    // start refused in down mode at zero; lap ignored in IDLE
    do_load(8'h00, 1'b1);
    expect_val("down_zero_no_start", 0);
    pulse_ss(); check(running);
    expect_val("idle_lap_ignored", 0);
    pulse_lap(); check(lap_cnt);

    // five laps into a four-entry buffer
    do_load(8'h00, 1'b0);
    pulse_ss(); tick(4);
    for (int k = 0; k < 5; k++) begin
      pulse_lap(); tick(3);
    end
    pulse_ss();
    expect_val("laps_cnt", 4);
    expect_val("laps_full", 1);
    expect_val("laps_newest", 8'h05);
    check(lap_cnt); check(lap_full); check(lap_bcd);
    expect_val("next_1", 8'h04); pulse_next(); check(lap_bcd);
    expect_val("next_2", 8'h03); pulse_next(); check(lap_bcd);
    expect_val("next_3", 8'h02); pulse_next(); check(lap_bcd);
    expect_val("next_wrap", 8'h05); pulse_next(); check(lap_bcd);
    // lap beats lap_next; paused time is 06
    expect_val("lap_wins", 8'h06);
    expect_val("lap_wins_cnt", 4);
    lap = 1'b1; lap_next = 1'b1; tick(1); lap = 1'b0; lap_next = 1'b0;
    check(lap_bcd); check(lap_cnt);

    // load clears laps; split freezes display
    expect_val("load_clr_cnt", 0);
    expect_val("load_clr_bcd", 0);
    do_load(8'h00, 1'b0);
    check(lap_cnt); check(lap_bcd);
    pulse_ss(); tick(12);
    split = 1'b1; tick(1); split = 1'b0;
    tick(15);
    expect_val("split_disp", 8'h03);
    expect_val("split_active", 1);
    expect_val("split_time", 8'h07);
    check(disp_bcd); check(split_active); check(time_bcd);
    expect_val("ss_clr_split", 0);
    expect_val("ss_disp_live", 8'h07);
    pulse_ss(); check(split_active); check(disp_bcd);

    // reset mid-RUN with laps and down direction
    do_load(8'h50, 1'b1);
    dir = 1'b0;
    pulse_ss(); pulse_lap(); pulse_lap(); pulse_lap();
    expect_val("pre_rst_cnt", 3);
    check(lap_cnt);
    reset = 1'b1; tick(1); reset = 1'b0;
    expect_val("mid_rst_time", 0);
    expect_val("mid_rst_running", 0);
    expect_val("mid_rst_lap_cnt", 0);
    expect_val("mid_rst_lap_bcd", 0);
    expect_val("mid_rst_full", 0);
    expect_val("mid_rst_disp", 0);
    check(time_bcd); check(running); check(lap_cnt);
    check(lap_bcd); check(lap_full); check(disp_bcd);
    expect_val("post_rst_up", 8'h01);
    pulse_ss(); tick(4); check(time_bcd);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
